// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, branch-type encoding and the
// branch resolver's FSM states.
package cpu_pkg;

  localparam int ADDR_W = 19;
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } br_type_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT     = 2'b01,
    S_REDIRECT = 2'b10
  } br_state_t;

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational check for whether a conditional branch in ID still depends on
// a result being produced in EX or loaded in MEM. Register 0 never hazards.
module branch_hazard_detect
  import cpu_pkg::*;
(
  input  logic [1:0]        br_type,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] mem_rd,
  output logic              haz
);

  br_type_t bt;
  logic     is_cond;
  logic     ex_hit;
  logic     mem_hit;

  assign bt      = br_type_t'(br_type);
  assign is_cond = (bt == BR_BEQ) || (bt == BR_BNE);
  assign ex_hit  = ex_regwrite && (ex_rd != '0) && ((ex_rd == rs1) || (ex_rd == rs2));
  assign mem_hit = mem_memread && (mem_rd != '0) && ((mem_rd == rs1) || (mem_rd == rs2));
  assign haz     = is_cond && (ex_hit || mem_hit);

endmodule

// File: rtl/branch_resolver.sv
// Decode-stage branch resolution: stalls on operand hazards, then issues a
// one-cycle redirect + IF/ID flush for taken branches. Define BRANCH_STATS_EN
// to build the saturating branch/taken statistics counters.
module branch_resolver
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [1:0]        id_br_type,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] id_offset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              zero,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] mem_rd,
  output logic              stall,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if,
  output logic              hazard_err,
  output logic [15:0]       br_total_cnt,
  output logic [15:0]       br_taken_cnt
);

  localparam int WCW = $clog2(MAX_WAIT + 2);

  br_state_t         state, next_state;
  br_type_t          bt;
  logic              haz_raw;
  logic              br;
  logic              taken;
  logic              eval;
  logic [ADDR_W-1:0] target_q;
  logic [WCW-1:0]    wait_cnt;

  branch_hazard_detect u_haz (
    .br_type     (id_br_type),
    .rs1         (id_rs1),
    .rs2         (id_rs2),
    .ex_regwrite (ex_regwrite),
    .ex_rd       (ex_rd),
    .mem_memread (mem_memread),
    .mem_rd      (mem_rd),
    .haz         (haz_raw)
  );

  assign bt    = br_type_t'(id_br_type);
  assign br    = id_valid && (bt != BR_NONE);
  assign taken = (bt == BR_JMP) || ((bt == BR_BEQ) && zero) || ((bt == BR_BNE) && !zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // ID contents are only trusted in IDLE/WAIT; in REDIRECT they are wrong-path.
  // Stall is also forced low during reset so every output reads 0 immediately.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    eval       = 1'b0;
    case (state)
      S_IDLE, S_WAIT: begin
        if (!br) begin
          next_state = S_IDLE;
        end else if (haz_raw) begin
          stall      = !rst;
          next_state = S_WAIT;
        end else begin
          eval       = 1'b1;
          next_state = taken ? S_REDIRECT : S_IDLE;
        end
      end
      S_REDIRECT: next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                target_q <= '0;
    else if (eval && taken) target_q <= id_pc + id_offset;
  end

  assign redirect_valid = (state == S_REDIRECT);
  assign flush_if       = (state == S_REDIRECT);
  assign redirect_pc    = target_q;

  // The error fires on the stalled cycle that pushes the count past MAX_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= '0;
      hazard_err <= 1'b0;
    end else if (stall) begin
      if (wait_cnt <= WCW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt >= WCW'(MAX_WAIT)) hazard_err <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] total_q;
  logic [15:0] taken_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
      taken_q <= '0;
    end else if (eval) begin
      if (total_q != 16'hFFFF)           total_q <= total_q + 16'd1;
      if (taken && taken_q != 16'hFFFF)  taken_q <= taken_q + 16'd1;
    end
  end

  assign br_total_cnt = total_q;
  assign br_taken_cnt = taken_q;
`else
  assign br_total_cnt = '0;
  assign br_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver; expected values are hand
// computed, statistics expectations follow whether BRANCH_STATS_EN is defined.
module tb_branch_resolver;
  import cpu_pkg::*;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [1:0]        id_br_type;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_offset;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              zero;
  logic              ex_regwrite;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush_if;
  logic              hazard_err;
  logic [15:0]       br_total_cnt;
  logic [15:0]       br_taken_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolver dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_br_type     (id_br_type),
    .id_pc          (id_pc),
    .id_offset      (id_offset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .zero           (zero),
    .ex_regwrite    (ex_regwrite),
    .ex_rd          (ex_rd),
    .mem_memread    (mem_memread),
    .mem_rd         (mem_rd),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if       (flush_if),
    .hazard_err     (hazard_err),
    .br_total_cnt   (br_total_cnt),
    .br_taken_cnt   (br_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] stat(input int n);
`ifdef BRANCH_STATS_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic applyStimulus(input logic v, input logic [1:0] t,
                               input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] off,
                               input logic [REG_AW-1:0] r1, input logic [REG_AW-1:0] r2,
                               input logic z, input logic exw, input logic [REG_AW-1:0] exrd,
                               input logic memr, input logic [REG_AW-1:0] memrd);
    id_valid    = v;
    id_br_type  = t;
    id_pc       = pc;
    id_offset   = off;
    id_rs1      = r1;
    id_rs2      = r2;
    zero        = z;
    ex_regwrite = exw;
    ex_rd       = exrd;
    mem_memread = memr;
    mem_rd      = memrd;
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, BR_NONE, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    checkOutput("reset_stall",   32'(stall), 32'd0);
    checkOutput("reset_rv",      32'(redirect_valid), 32'd0);
    checkOutput("reset_pc",      32'(redirect_pc), 32'd0);
    checkOutput("reset_flush",   32'(flush_if), 32'd0);
    checkOutput("reset_err",     32'(hazard_err), 32'd0);
    checkOutput("reset_total",   32'(br_total_cnt), 32'd0);
    checkOutput("reset_taken",   32'(br_taken_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // BEQ taken, no hazard
    applyStimulus(1'b1, BR_BEQ, 19'h00010, 19'h00008, 3'd1, 3'd2, 1'b1, 1'b0, '0, 1'b0, '0);
    checkOutput("beq_stall", 32'(stall), 32'd0);
    checkOutput("beq_rv_early", 32'(redirect_valid), 32'd0);
    tick();
    checkOutput("beq_rv", 32'(redirect_valid), 32'd1);
    checkOutput("beq_flush", 32'(flush_if), 32'd1);
    checkOutput("beq_pc", 32'(redirect_pc), 32'h00018);
    checkOutput("beq_total", 32'(br_total_cnt), stat(1));
    checkOutput("beq_taken", 32'(br_taken_cnt), stat(1));
    // wrong-path BNE during REDIRECT must be ignored
    applyStimulus(1'b1, BR_BNE, 19'h00100, 19'h00040, 3'd1, 3'd2, 1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("redir_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("wrongpath_rv", 32'(redirect_valid), 32'd0);

    // BNE not taken, then BNE taken with negative offset
    applyStimulus(1'b1, BR_BNE, 19'h00020, 19'h7FFFC, 3'd1, 3'd2, 1'b1, 1'b0, '0, 1'b0, '0);
    checkOutput("bne_nt_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("bne_nt_rv", 32'(redirect_valid), 32'd0);
    checkOutput("bne_nt_total", 32'(br_total_cnt), stat(2));
    checkOutput("bne_nt_taken", 32'(br_taken_cnt), stat(1));
    applyStimulus(1'b1, BR_BNE, 19'h00020, 19'h7FFFC, 3'd1, 3'd2, 1'b0, 1'b0, '0, 1'b0, '0);
    tick();
    checkOutput("bne_rv", 32'(redirect_valid), 32'd1);
    checkOutput("bne_pc", 32'(redirect_pc), 32'h0001C);
    checkOutput("bne_total", 32'(br_total_cnt), stat(3));
    checkOutput("bne_taken", 32'(br_taken_cnt), stat(2));
    idleInputs();
    tick();
    checkOutput("bne_rv_drop", 32'(redirect_valid), 32'd0);

    // BEQ with a 2-cycle EX hazard on rs1
    applyStimulus(1'b1, BR_BEQ, 19'h00040, 19'h00010, 3'd3, 3'd5, 1'b1, 1'b1, 3'd3, 1'b0, '0);
    checkOutput("exhaz_stall1", 32'(stall), 32'd1);
    tick();
    checkOutput("exhaz_rv1", 32'(redirect_valid), 32'd0);
    checkOutput("exhaz_stall2", 32'(stall), 32'd1);
    tick();
    applyStimulus(1'b1, BR_BEQ, 19'h00040, 19'h00010, 3'd3, 3'd5, 1'b1, 1'b0, 3'd3, 1'b0, '0);
    checkOutput("exhaz_eval_stall", 32'(stall), 32'd0);
    checkOutput("exhaz_eval_rv", 32'(redirect_valid), 32'd0);
    tick();
    checkOutput("exhaz_rv", 32'(redirect_valid), 32'd1);
    checkOutput("exhaz_pc", 32'(redirect_pc), 32'h00050);
    checkOutput("exhaz_err", 32'(hazard_err), 32'd0);
    checkOutput("exhaz_total", 32'(br_total_cnt), stat(4));
    idleInputs();
    tick();

    // BNE with a 5-cycle MEM load hazard on rs2: error after the 4th stall
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, BR_BNE, 19'h00100, 19'h00020, 3'd1, 3'd6, 1'b0, 1'b0, '0, 1'b1, 3'd6);
      checkOutput($sformatf("memhaz_stall%0d", i), 32'(stall), 32'd1);
      checkOutput($sformatf("memhaz_err%0d", i), 32'(hazard_err), (i >= 5) ? 32'd1 : 32'd0);
      tick();
    end
    applyStimulus(1'b1, BR_BNE, 19'h00100, 19'h00020, 3'd1, 3'd6, 1'b0, 1'b0, '0, 1'b0, 3'd6);
    checkOutput("memhaz_eval_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("memhaz_rv", 32'(redirect_valid), 32'd1);
    checkOutput("memhaz_pc", 32'(redirect_pc), 32'h00120);
    checkOutput("memhaz_err_sticky", 32'(hazard_err), 32'd1);
    checkOutput("memhaz_total", 32'(br_total_cnt), stat(5));
    checkOutput("memhaz_taken", 32'(br_taken_cnt), stat(4));
    idleInputs();
    tick();
    checkOutput("memhaz_err_hold", 32'(hazard_err), 32'd1);

    // EX producer writing r0 is not a hazard
    applyStimulus(1'b1, BR_BEQ, 19'h00200, 19'h00004, 3'd0, 3'd2, 1'b0, 1'b1, 3'd0, 1'b0, '0);
    checkOutput("r0_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("r0_rv", 32'(redirect_valid), 32'd0);
    checkOutput("r0_total", 32'(br_total_cnt), stat(6));

    // JMP wraps the address space and ignores a matching EX producer
    applyStimulus(1'b1, BR_JMP, 19'h7FFFE, 19'h00004, 3'd3, 3'd3, 1'b0, 1'b1, 3'd3, 1'b0, '0);
    checkOutput("jmp_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("jmp_rv", 32'(redirect_valid), 32'd1);
    checkOutput("jmp_pc", 32'(redirect_pc), 32'h00002);
    checkOutput("jmp_taken", 32'(br_taken_cnt), stat(5));
    idleInputs();
    tick();

    // Reset in WAIT discards the branch and clears the sticky error
    applyStimulus(1'b1, BR_BEQ, 19'h00300, 19'h00010, 3'd2, 3'd4, 1'b1, 1'b1, 3'd2, 1'b0, '0);
    checkOutput("rstwait_stall_pre", 32'(stall), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rstwait_stall", 32'(stall), 32'd0);
    checkOutput("rstwait_err", 32'(hazard_err), 32'd0);
    checkOutput("rstwait_rv", 32'(redirect_valid), 32'd0);
    checkOutput("rstwait_total", 32'(br_total_cnt), 32'd0);
    idleInputs();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rstwait_no_redir", 32'(redirect_valid), 32'd0);
    tick();
    checkOutput("rstwait_no_redir2", 32'(redirect_valid), 32'd0);

    // Reset in REDIRECT drops the redirect at once
    applyStimulus(1'b1, BR_BEQ, 19'h00400, 19'h00010, 3'd1, 3'd2, 1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    checkOutput("rstredir_rv_pre", 32'(redirect_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstredir_rv", 32'(redirect_valid), 32'd0);
    checkOutput("rstredir_flush", 32'(flush_if), 32'd0);
    checkOutput("rstredir_pc", 32'(redirect_pc), 32'd0);
    checkOutput("rstredir_stall", 32'(stall), 32'd0);
    idleInputs();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rstredir_no_redir", 32'(redirect_valid), 32'd0);
    checkOutput("rstredir_flush_after", 32'(flush_if), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
